// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
// The digit type and lock FSM states live here so the top and digit adder agree.
package score_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum {IDLE, LOCKED} lock_state_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

endpackage : score_pkg

// File: rtl/bcd_score_counter_if.sv
// Collision inputs and scoreboard outputs of the BCD score counter.
// The master drives the collision side; the slave is the counter itself.
interface bcd_score_counter_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    hit;
  logic                    bonus;
  logic                    enable;
  logic                    game_over;
  logic                    score_cheat;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    score_pulse;
  logic                    overflow;

  modport master (
    output hit, bonus, enable, game_over, score_cheat,
    input  digits, score_pulse, overflow
  );

  modport slave (
    input  hit, bonus, enable, game_over, score_cheat,
    output digits, score_pulse, overflow
  );

endinterface : bcd_score_counter_if

// File: rtl/bcd_digit_add.sv
// One decimal digit of the ripple adder: d + addend + cin, folded back into 0..9.
// Legal BCD inputs keep the raw sum at or below 19, so one correction step suffices.
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_t d_i,
  input  bcd_t addend_i,
  input  logic cin_i,
  output bcd_t d_o,
  output logic cout_o
);

  logic [4:0] sum;

  assign sum    = {1'b0, d_i} + {1'b0, addend_i} + {4'b0000, cin_i};
  assign cout_o = (sum > 5'd9);
  assign d_o    = cout_o ? bcd_t'(sum - 5'd10) : sum[3:0];

endmodule : bcd_digit_add

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score register: one award per collision, cheat preset, game-over clear,
// and wrap or saturate on overflow. Outputs are registered and aligned with the new score.
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REGULAR_SCORE = 1,
  parameter int BONUS_SCORE   = 2,
  parameter int CHEAT_DIGIT   = 9,
  parameter bit WRAP_MODE     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_score_counter_if.slave   bus
);

  localparam int W = 4 * NUM_DIGITS;

  lock_state_t    state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic           pulse_q, pulse_d;
  logic           ovf_q, ovf_d;

  bcd_t            amount;
  logic [W-1:0]    sum_digits;
  logic [NUM_DIGITS:0] carry;
  logic            award;
  logic            all_nines;

  assign amount    = bus.bonus ? bcd_t'(BONUS_SCORE) : bcd_t'(REGULAR_SCORE);
  assign all_nines = (digits_q == {NUM_DIGITS{BCD_MAX}});
  assign award     = (state_q == IDLE) && bus.enable && (bus.hit || bus.bonus);
  assign carry[0]  = 1'b0;

  // Only digit 0 sees the award amount; higher digits add just the incoming carry.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_add u_add (
      .d_i      (digits_q[4*i +: 4]),
      .addend_i ((i == 0) ? amount : BCD_ZERO),
      .cin_i    (carry[i]),
      .d_o      (sum_digits[4*i +: 4]),
      .cout_o   (carry[i+1])
    );
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    digits_d = digits_q;
    pulse_d  = 1'b0;
    ovf_d    = 1'b0;
    if (bus.game_over) begin
      digits_d = '0;
      state_d  = IDLE;
    end else if (bus.score_cheat) begin
      digits_d = {NUM_DIGITS{bcd_t'(CHEAT_DIGIT)}};
    end else if (award) begin
      state_d = LOCKED;
      pulse_d = 1'b1;
      if (carry[NUM_DIGITS]) begin
        digits_d = WRAP_MODE ? sum_digits : {NUM_DIGITS{BCD_MAX}};
        // A saturated counter already reported its overflow; stay quiet until it moves.
        ovf_d    = WRAP_MODE || !all_nines;
      end else begin
        digits_d = sum_digits;
      end
    end else if ((state_q == LOCKED) && !bus.hit && !bus.bonus) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= IDLE;
      digits_q <= '0;
      pulse_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      pulse_q  <= pulse_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.score_pulse = pulse_q;
  assign bus.overflow    = ovf_q;

endmodule : bcd_score_counter

// File: tb/tb_bcd_score_counter.sv
// Drives a wrapping and a saturating counter with the same stimulus and compares both
// every cycle against an integer score model, plus directed scenario checks.
module tb_bcd_score_counter;

  localparam int ND    = 4;
  localparam int REG   = 1;
  localparam int BON   = 2;
  localparam int CHEAT = 9;
  localparam int MODV  = 10000;
  localparam int MAXV  = MODV - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bcd_score_counter_if #(.NUM_DIGITS(ND)) if_w ();
  bcd_score_counter_if #(.NUM_DIGITS(ND)) if_s ();

  bcd_score_counter #(
    .NUM_DIGITS(ND), .REGULAR_SCORE(REG), .BONUS_SCORE(BON),
    .CHEAT_DIGIT(CHEAT), .WRAP_MODE(1'b1)
  ) u_dut_wrap (.clk(clk), .reset(reset), .bus(if_w));

  bcd_score_counter #(
    .NUM_DIGITS(ND), .REGULAR_SCORE(REG), .BONUS_SCORE(BON),
    .CHEAT_DIGIT(CHEAT), .WRAP_MODE(1'b0)
  ) u_dut_sat (.clk(clk), .reset(reset), .bus(if_s));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Reference model: index 0 wraps, index 1 saturates.
  int m_score  [2];
  bit m_locked [2];
  bit m_pulse  [2];
  bit m_ovf    [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*ND-1:0] to_bcd(input int value);
    logic [4*ND-1:0] v;
    int x;
    x = value;
    v = '0;
    for (int i = 0; i < ND; i++) begin
      v[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return v;
  endfunction

  function automatic int bcd_val(input logic [4*ND-1:0] v);
    int r;
    r = 0;
    for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic int cheat_value();
    int v;
    v = 0;
    for (int i = 0; i < ND; i++) v = v * 10 + CHEAT;
    return v;
  endfunction

  task automatic model_step(input int k, input bit h, input bit b, input bit e,
                            input bit g, input bit c, input bit r);
    int s;
    m_pulse[k] = 1'b0;
    m_ovf[k]   = 1'b0;
    if (r || g) begin
      m_score[k]  = 0;
      m_locked[k] = 1'b0;
    end else if (c) begin
      m_score[k] = cheat_value();
    end else if (!m_locked[k] && e && (h || b)) begin
      s = m_score[k] + (b ? BON : REG);
      m_pulse[k]  = 1'b1;
      m_locked[k] = 1'b1;
      if (s > MAXV) begin
        if (k == 0) begin
          m_score[k] = s - MODV;
          m_ovf[k]   = 1'b1;
        end else begin
          m_ovf[k]   = (m_score[k] != MAXV);
          m_score[k] = MAXV;
        end
      end else begin
        m_score[k] = s;
      end
    end else if (m_locked[k] && !h && !b) begin
      m_locked[k] = 1'b0;
    end
  endtask

  task automatic cycle(input bit h, input bit b, input bit e,
                       input bit g = 1'b0, input bit c = 1'b0, input bit r = 1'b0);
    if_w.hit = h; if_w.bonus = b; if_w.enable = e; if_w.game_over = g; if_w.score_cheat = c;
    if_s.hit = h; if_s.bonus = b; if_s.enable = e; if_s.game_over = g; if_s.score_cheat = c;
    reset = r;
    @(posedge clk);
    model_step(0, h, b, e, g, c, r);
    model_step(1, h, b, e, g, c, r);
    #1;
    if (if_w.score_pulse === 1'b1) pulse_cnt++;
    check("wrap_digits",   32'(if_w.digits),   32'(to_bcd(m_score[0])));
    check("wrap_pulse",    32'(if_w.score_pulse), 32'(m_pulse[0]));
    check("wrap_overflow", 32'(if_w.overflow), 32'(m_ovf[0]));
    check("sat_digits",    32'(if_s.digits),   32'(to_bcd(m_score[1])));
    check("sat_pulse",     32'(if_s.score_pulse), 32'(m_pulse[1]));
    check("sat_overflow",  32'(if_s.overflow), 32'(m_ovf[1]));
  endtask

  // One award followed by a release cycle so the next award is accepted.
  task automatic award_n(input int n, input bit b);
    for (int i = 0; i < n; i++) begin
      cycle(!b, b, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_score[k] = 0; m_locked[k] = 1'b0; m_pulse[k] = 1'b0; m_ovf[k] = 1'b0;
    end
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("reset_digits", 32'(bcd_val(if_w.digits)), 32'd0);

    // Held hit awards once.
    pulse_cnt = 0;
    repeat (5) cycle(1, 0, 1);
    cycle(0, 0, 1);
    check("hold5_digits", 32'(bcd_val(if_w.digits)), 32'd1);
    check("hold5_pulses", 32'(pulse_cnt), 32'd1);

    // 0098 + bonus -> 0100
    cycle(0, 0, 0, 1);
    award_n(49, 1'b1);
    check("start_98", 32'(bcd_val(if_w.digits)), 32'd98);
    award_n(1, 1'b1);
    check("carry_100", 32'(bcd_val(if_w.digits)), 32'd100);

    // 0099 + hit&bonus -> 0101, one award
    cycle(0, 0, 0, 1);
    award_n(49, 1'b1);
    award_n(1, 1'b0);
    check("start_99", 32'(bcd_val(if_w.digits)), 32'd99);
    cycle(1, 1, 1);
    check("both_101", 32'(bcd_val(if_w.digits)), 32'd101);
    check("both_pulse", 32'(if_w.score_pulse), 32'd1);
    cycle(0, 0, 1);

    // Cheat to 9999, then bonus: wrap -> 0001 with overflow; saturate stays silent.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 1);
    check("wrap_9999_plus2", 32'(bcd_val(if_w.digits)), 32'd1);
    check("wrap_9999_ovf", 32'(if_w.overflow), 32'd1);
    check("sat_9999_ovf", 32'(if_s.overflow), 32'd0);
    cycle(0, 0, 1);

    // Saturate from 9998.
    cycle(0, 0, 0, 1);
    award_n(4999, 1'b1);
    check("start_9998", 32'(bcd_val(if_s.digits)), 32'd9998);
    cycle(0, 1, 1);
    check("sat_digits_first", 32'(bcd_val(if_s.digits)), 32'd9999);
    check("sat_ovf_first", 32'(if_s.overflow), 32'd1);
    check("wrap_from_9998", 32'(bcd_val(if_w.digits)), 32'd0);
    cycle(0, 0, 1);
    cycle(0, 1, 1);
    check("sat_digits_second", 32'(bcd_val(if_s.digits)), 32'd9999);
    check("sat_ovf_second", 32'(if_s.overflow), 32'd0);
    check("sat_pulse_second", 32'(if_s.score_pulse), 32'd1);
    cycle(0, 0, 1);

    // Late enable inside one collision awards once.
    cycle(0, 0, 0, 1);
    pulse_cnt = 0;
    repeat (3) cycle(1, 0, 0);
    repeat (3) cycle(1, 0, 1);
    cycle(0, 0, 1);
    check("late_enable_digits", 32'(bcd_val(if_w.digits)), 32'd1);
    check("late_enable_pulses", 32'(pulse_cnt), 32'd1);

    // game_over while LOCKED at 0457 with hit held.
    cycle(0, 0, 0, 1);
    award_n(228, 1'b1);
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    check("locked_457", 32'(bcd_val(if_w.digits)), 32'd457);
    cycle(1, 0, 1, 1);
    check("gameover_clear", 32'(bcd_val(if_w.digits)), 32'd0);
    cycle(1, 0, 1);
    check("rearm_award", 32'(bcd_val(if_w.digits)), 32'd1);
    check("rearm_pulse", 32'(if_w.score_pulse), 32'd1);
    cycle(0, 0, 1);

    // Cheat beats award; reset beats cheat.
    cycle(1, 0, 1, 0, 1);
    check("cheat_digits", 32'(bcd_val(if_w.digits)), 32'd9999);
    check("cheat_no_pulse", 32'(if_w.score_pulse), 32'd0);
    cycle(0, 0, 0, 0, 1, 1);
    check("reset_over_cheat", 32'(bcd_val(if_w.digits)), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bcd_score_counter
